fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the control unit. It owns the program counter, fetches 32-bit instructions from instruction memory through a request/acknowledge handshake, and holds each instruction in an instruction register. It presents the decoded fields (op, f3, f7, register indices, immediate) to the control unit and datapath, then advances the PC by +4 or to the branch target when downstream consumes the instruction.

## Interface
- XLEN, 64, datapath/PC width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address; equals pc
- imem_ack  in  1  instruction data valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack
- instr_valid  out  1  held instruction is valid for downstream
- instr_ready  in  1  downstream consumes the instruction this cycle
- branch  in  1  branch taken from control unit, already gated with ALU zero
- pc  out  XLEN  address of the held instruction
- instr  out  32  instruction register
- op  out  7  instr[6:0]
- f3  out  3  instr[14:12]
- f7  out  7  instr[31:25]
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- imm  out  XLEN  sign-extended immediate selected by op
- illegal  out  1  unsupported opcode trapped (macro-dependent)

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next clock.
- FETCH: imem_req=1; imem_addr=pc held stable. On imem_ack, instr<=imem_rdata and the FSM moves to ISSUE.
- ISSUE: instr_valid=1; imem_req=0. On instr_ready, pc<=next_pc and the FSM moves to FETCH. Without instr_ready, the FSM stays in ISSUE and all outputs hold.
- next_pc = branch ? pc + imm_b : pc + 4. Addition is modulo 2^XLEN, so wrap-around is silent. next_pc[1:0] is forced to 00.
- branch is sampled only in ISSUE with instr_ready. It is ignored otherwise.
- imm selection by op:
  - 0000011 (ld): I-type, instr[31:20].
  - 0100011 (sd): S-type, {instr[31:25], instr[11:7]}.
  - 1100011 (beq): B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - Any other op: imm=0.
  - All immediates are sign-extended from bit 31 to XLEN.
- imem_ack outside FETCH is ignored.
- Field outputs are combinational slices of instr and are valid whenever instr_valid=1.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=32'h00000000.
  - imem_req=0, instr_valid=0, illegal=0.
  - op/f3/f7/rd/rs1/rs2=0, imm=0.
- First imem_req is asserted on the second rising edge after rst_n deasserts: one cycle in IDLE.
- Best-case throughput with imem_ack in the same cycle as the request and instr_ready asserted immediately: one instruction per 2 cycles (FETCH, then ISSUE).
- imem_ack latency N cycles adds N cycles. imem_addr does not change while imem_req=1.
- instr_valid rises the cycle after the accepting ack and falls the cycle after instr_ready.
- Reset mid-fetch or mid-issue aborts immediately: any in-flight ack is discarded and pc returns to RESET_PC.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined:
  - At the transition into ISSUE, if op is not one of 0110011, 0000011, 0100011 or 1100011, the FSM enters HALT instead.
  - In HALT: illegal=1, instr_valid=0, imem_req=0, pc frozen at the offending address.
  - HALT is left only by reset.
- FETCH_ILLEGAL_TRAP_EN undefined:
  - Every opcode is issued normally and illegal is tied to 0.
  - The HALT state is not compiled in.

## Test plan
- Reset release, RESET_PC=0, imem_ack tied 1, instr_ready tied 1 -> imem_addr sequence 0, 4, 8, 12; instr_valid pulses every 2nd cycle; first imem_req exactly one cycle after reset release.
- Fetch 32'h00B50533 (add x10,x10,x11) -> op=0110011, f3=000, f7=0000000, rd=10, rs1=10, rs2=11, imm=0.
- Instruction 32'hFE0008E3 (beq, offset -16) at pc=0x20 with branch=1 at accept -> imm=0xFFFF_FFFF_FFFF_FFF0, next imem_addr=0x10. Same instruction with branch=0 -> next imem_addr=0x24.
- imem_ack delayed 3 cycles, then instr_ready held low 4 cycles -> imem_addr stable throughout; instr and pc unchanged while stalled; no PC advance until the instr_ready cycle.
- Instruction 32'h0080B183 (ld x3,8(x1)) -> imm=8. Instruction 32'hFE313C23 (sd x3,-8(x2)) -> imm=0xFFFF_FFFF_FFFF_FFF8.
- FETCH_ILLEGAL_TRAP_EN defined, fetch 32'h00000013 (addi) -> illegal=1, instr_valid=0, imem_req=0 indefinitely; rst_n pulse -> illegal=0, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if: instruction-memory and issue bundle for fetch_stage  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic            branch;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid,
        input  instr_ready, branch,
        output pc, instr, op, f3, f7, rd, rs1, rs2, imm, illegal
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid,
        output instr_ready, branch,
        input  pc, instr, op, f3, f7, rd, rs1, rs2, imm, illegal
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage: PC, instruction fetch handshake and instruction register |
// | Optional macro FETCH_ILLEGAL_TRAP_EN: halt on unsupported opcodes.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire             clk,
    input  wire             rst_n,
    fetch_stage_if.master   bus
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
`ifdef FETCH_ILLEGAL_TRAP_EN
        ,S_HALT = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_next_pc;

    assign w_imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign w_imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign w_imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                      instr_q[30:25], instr_q[11:8], 1'b0};

    always_comb begin
        w_imm = '0;
        case (instr_q[6:0])
            OP_LOAD:   w_imm = w_imm_i;
            OP_STORE:  w_imm = w_imm_s;
            OP_BRANCH: w_imm = w_imm_b;
            default:   w_imm = '0;
        endcase
    end

    // Branch target uses the B-type immediate regardless of op; control only raises branch for branches.
    assign w_sum     = bus.branch ? (pc_q + w_imm_b) : (pc_q + XLEN'(4));
    assign w_next_pc = w_sum & ~(XLEN'(3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    if ((bus.imem_rdata[6:0] == OP_ALU)   || (bus.imem_rdata[6:0] == OP_LOAD) ||
                        (bus.imem_rdata[6:0] == OP_STORE) || (bus.imem_rdata[6:0] == OP_BRANCH))
                        state_d = S_ISSUE;
                    else
                        state_d = S_HALT;
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    pc_d    = w_next_pc;
                    state_d = S_FETCH;
                end
            end
`ifdef FETCH_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == S_ISSUE);
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[6:0];
    assign bus.f3          = instr_q[14:12];
    assign bus.f7          = instr_q[31:25];
    assign bus.rd          = instr_q[11:7];
    assign bus.rs1         = instr_q[19:15];
    assign bus.rs2         = instr_q[24:20];
    assign bus.imm         = w_imm;
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign bus.illegal     = (state_q == S_HALT);
`else
    assign bus.illegal     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage: directed scoreboard bench for fetch_stage             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(64)) bus ();

    fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
        logic [63:0] imm;
        int          ack_dly;
        int          rdy_dly;
        bit          br;
        bit          junk_ack;
        int          gap;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
        logic [63:0] imm;
        int          gap;
    } rec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_consume = 0;
    logic [63:0] q_addr[$];
    rec_t        q_rec[$];
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (prev_req && bus.imem_req)
                chk("addr_stable", bus.imem_addr, prev_addr);
            if (prev_valid && bus.instr_valid) begin
                chk("pc_hold", bus.pc, prev_pc);
                chk("instr_hold", {32'h0, bus.instr}, {32'h0, prev_instr});
            end
            if (bus.imem_req && bus.imem_ack) begin
                if (q_addr.size() == 0) chk("addr_unexpected", 64'h1, 64'h0);
                else chk("imem_addr", bus.imem_addr, q_addr.pop_front());
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (q_rec.size() == 0) chk("issue_unexpected", 64'h1, 64'h0);
                else begin
                    rec_t r;
                    r = q_rec.pop_front();
                    chk("pc",      bus.pc, r.pc);
                    chk("instr",   {32'h0, bus.instr}, {32'h0, r.word});
                    chk("op",      {57'h0, bus.op},  {57'h0, r.word[6:0]});
                    chk("f3",      {61'h0, bus.f3},  {61'h0, r.word[14:12]});
                    chk("f7",      {57'h0, bus.f7},  {57'h0, r.word[31:25]});
                    chk("rd",      {59'h0, bus.rd},  {59'h0, r.word[11:7]});
                    chk("rs1",     {59'h0, bus.rs1}, {59'h0, r.word[19:15]});
                    chk("rs2",     {59'h0, bus.rs2}, {59'h0, r.word[24:20]});
                    chk("imm",     bus.imm, r.imm);
                    chk("illegal", {63'h0, bus.illegal}, 64'h0);
                    if (r.gap != 0)
                        chk("issue_gap", 64'(cyc - last_consume), 64'(r.gap));
                end
                last_consume = cyc;
            end
            prev_req   = bus.imem_req;
            prev_valid = bus.instr_valid;
            prev_addr  = bus.imem_addr;
            prev_pc    = bus.pc;
            prev_instr = bus.instr;
        end else begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        bus.branch = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc",    bus.pc, 64'h0);
        chk("rst_addr",  bus.imem_addr, 64'h0);
        chk("rst_instr", {32'h0, bus.instr}, 64'h0);
        chk("rst_req",   {63'h0, bus.imem_req}, 64'h0);
        chk("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
        chk("rst_ill",   {63'h0, bus.illegal}, 64'h0);
        chk("rst_imm",   bus.imm, 64'h0);
        chk("rst_op",    {57'h0, bus.op}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {63'h0, bus.imem_req}, 64'h0);
        @(negedge clk);
        #1;
        chk("first_req", {63'h0, bus.imem_req}, 64'h1);
        @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!bus.imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = bus.imem_req;
        if (!ok) chk("req_timeout", 64'h0, 64'h1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        rec_t r;
        wait_req(ok);
        if (!ok) return;
        q_addr.push_back(v.pc);
        bus.imem_ack = 1'b0;
        repeat (v.ack_dly) @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = v.word;
        r.word = v.word; r.pc = v.pc; r.imm = v.imm; r.gap = v.gap;
        q_rec.push_back(r);
        @(negedge clk);
        bus.imem_ack = v.junk_ack;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk("valid_rise", {63'h0, bus.instr_valid}, 64'h1);
        bus.instr_ready = 1'b0;
        repeat (v.rdy_dly) @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        bus.branch = v.br;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.branch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        vec_t v;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b0;
        bus.branch = 1'b0;

        //          word          pc     imm                    ack rdy br junk gap
        vecs[0] = '{32'h00B50533, 64'h00, 64'h0,                 0, 0, 0, 0, 0};
        vecs[1] = '{32'h0080B183, 64'h04, 64'h8,                 0, 0, 0, 0, 2};
        vecs[2] = '{32'hFE313C23, 64'h08, 64'hFFFFFFFFFFFFFFF8,  0, 0, 0, 0, 2};
        vecs[3] = '{32'h00B50533, 64'h0C, 64'h0,                 3, 4, 0, 1, 0};
        vecs[4] = '{32'h00000863, 64'h10, 64'h10,                0, 0, 1, 0, 0};
        vecs[5] = '{32'hFE0008E3, 64'h20, 64'hFFFFFFFFFFFFFFF0,  0, 0, 0, 0, 0};
        vecs[6] = '{32'hFE000EE3, 64'h24, 64'hFFFFFFFFFFFFFFFC,  1, 1, 1, 0, 0};
        vecs[7] = '{32'hFE0008E3, 64'h20, 64'hFFFFFFFFFFFFFFF0,  0, 0, 1, 0, 0};
        vecs[8] = '{32'h00B50533, 64'h10, 64'h0,                 0, 0, 0, 0, 0};

        apply_reset();
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Abort mid-issue: ack still high when reset hits, pc must return to 0.
        wait_req(ok);
        if (ok) begin
            q_addr.push_back(64'h14);
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'h00B50533;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_pc",    bus.pc, 64'h0);
            chk("abort_valid", {63'h0, bus.instr_valid}, 64'h0);
            chk("abort_instr", {32'h0, bus.instr}, 64'h0);
        end
        apply_reset();

`ifdef FETCH_ILLEGAL_TRAP_EN
        wait_req(ok);
        if (ok) begin
            q_addr.push_back(64'h0);
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'h00000013;
            @(negedge clk);
            bus.imem_ack = 1'b1;
            bus.instr_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
                #1;
                chk("halt_illegal", {63'h0, bus.illegal}, 64'h1);
                chk("halt_valid",   {63'h0, bus.instr_valid}, 64'h0);
                chk("halt_req",     {63'h0, bus.imem_req}, 64'h0);
                chk("halt_pc",      bus.pc, 64'h0);
                @(negedge clk);
            end
        end
        apply_reset();
        v = '{32'h00B50533, 64'h0, 64'h0, 0, 0, 0, 0, 0};
        run_vec(v);
`else
        v = '{32'h00000013, 64'h0, 64'h0, 0, 0, 0, 0, 0};
        run_vec(v);
        v = '{32'h00B50533, 64'h4, 64'h0, 0, 0, 0, 0, 2};
        run_vec(v);
`endif

        repeat (3) @(negedge clk);
        chk("addr_queue_empty", 64'(q_addr.size()), 64'h0);
        chk("rec_queue_empty",  64'(q_rec.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
